// File: rtl/cpu_wb_pkg.sv
// Shared types and defaults for the CPU register-file writeback arbiter.
package cpu_wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam int unsigned DEPTH_DEFAULT        = 4;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/cpu_wb_fifo.sv
// Small synchronous FIFO holding long-latency results; head is visible combinationally.
module cpu_wb_fifo
  import cpu_wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  wb_entry_t       push_entry,
  input  logic            pop,
  output wb_entry_t       head,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/cpu_writeback_arbiter.sv
// Owns the register-file write port: pipeline writeback first, then buffered long-latency results.
// Optional starvation guard (wb_hold) is enabled by defining CPU_WB_STARVE_GUARD_EN.
module cpu_writeback_arbiter
  import cpu_wb_pkg::*;
#(
  parameter int unsigned DEPTH        = DEPTH_DEFAULT,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  wb_hold,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_data,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  input  logic [REG_ADDR_W-1:0] q_rd,
  output logic                  q_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_a,
  output logic [XLEN-1:0]       rf_wd
);

  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned NumRegs = 1 << REG_ADDR_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT == 0) begin : g_param_check
    $error("cpu_writeback_arbiter: DEPTH must be a power of two >= 2, STARVE_LIMIT >= 1");
  end

  wb_entry_t        fifo_head, push_entry;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]  fifo_count;
  logic             slot_used;
  logic [NumRegs-1:0] pending_q, pending_d;

  assign slot_used  = wb_valid && (wb_rd != '0);
  assign fifo_pop   = !slot_used && !fifo_empty;
  assign lu_ready   = !fifo_full;
  // x0 results complete the handshake but are never stored.
  assign fifo_push  = lu_valid && lu_ready && (lu_rd != '0);
  assign push_entry = '{rd: lu_rd, data: lu_data};

  cpu_wb_fifo #(
    .DEPTH (DEPTH),
    .CntW  (CntW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  count_full_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_full == (fifo_count == CntW'(DEPTH)));

  always_comb begin
    rf_we = 1'b0;
    rf_a  = '0;
    rf_wd = '0;
    if (slot_used) begin
      rf_we = 1'b1;
      rf_a  = wb_rd;
      rf_wd = wb_data;
    end else if (!fifo_empty) begin
      rf_we = 1'b1;
      rf_a  = fifo_head.rd;
      rf_wd = fifo_head.data;
    end
  end

  // Set is applied after clear so a same-cycle reissue stays pending.
  always_comb begin
    pending_d = pending_q;
    if (fifo_pop)  pending_d[fifo_head.rd] = 1'b0;
    if (iss_valid) pending_d[iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign q_stall = pending_q[q_rs1] | pending_q[q_rs2] | pending_q[q_rd];

`ifdef CPU_WB_STARVE_GUARD_EN
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  logic [StarveW-1:0] starve_q, starve_d;
  logic               hold_q, hold_d;
  logic               starved;

  assign starved = !fifo_empty && !fifo_pop;

  always_comb begin
    starve_d = '0;
    hold_d   = 1'b0;
    if (starved) begin
      if (starve_q == StarveW'(STARVE_LIMIT - 1)) hold_d = 1'b1;
      else                                        starve_d = starve_q + StarveW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      hold_q   <= hold_d;
    end
  end

  assign wb_hold = hold_q;
`else
  assign wb_hold = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_writeback_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_cpu_writeback_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0, lu_valid = 1'b0, iss_valid = 1'b0;
  logic [4:0]  wb_rd = '0, lu_rd = '0, iss_rd = '0, q_rs1 = '0, q_rs2 = '0, q_rd = '0;
  logic [31:0] wb_data = '0, lu_data = '0;
  logic        wb_hold, lu_ready, q_stall, rf_we;
  logic [4:0]  rf_a;
  logic [31:0] rf_wd;

  always #5 clk = ~clk;

  cpu_writeback_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_hold   (wb_hold),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .q_rd      (q_rd),
    .q_stall   (q_stall),
    .rf_we     (rf_we),
    .rf_a      (rf_a),
    .rf_wd     (rf_wd)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: buffered results in arrival order, pending set, unserviced-run length.
  logic [4:0]  m_rd[$];
  logic [31:0] m_data[$];
  bit          m_pend[32];
  int          m_run;
  bit          m_hold;

  task automatic model_clear();
    m_rd.delete();
    m_data.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_run  = 0;
    m_hold = 1'b0;
  endtask

  task automatic drive(input bit wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input bit iv, input logic [4:0] ird);
    wb_valid = wv; wb_rd = wrd; wb_data = wd;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    iss_valid = iv; iss_rd = ird;
  endtask

  task automatic query(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    q_rs1 = r1; q_rs2 = r2; q_rd = rd;
  endtask

  // Advance one clock, updating the model from the inputs currently applied.
  task automatic tick();
    bit slot, pop, push, unserviced;
    slot = wb_valid && wb_rd != 0;
    pop  = !slot && m_rd.size() > 0;
    push = lu_valid && m_rd.size() < DEPTH && lu_rd != 0;
    unserviced = m_rd.size() > 0 && !pop;
`ifdef CPU_WB_STARVE_GUARD_EN
    m_hold = 1'b0;
    if (unserviced) begin
      m_run++;
      if (m_run == STARVE_LIMIT) begin
        m_hold = 1'b1;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
`else
    m_run = unserviced ? m_run + 1 : 0;
`endif
    if (pop) begin
      m_pend[m_rd[0]] = 1'b0;
      void'(m_rd.pop_front());
      void'(m_data.pop_front());
    end
    if (push) begin
      m_rd.push_back(lu_rd);
      m_data.push_back(lu_data);
    end
    if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    query(0, 0, 0);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    query(5, 0, 0);
    #2;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL por_rf_we: got %b want 0", rf_we); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL por_lu_ready: got %b want 1", lu_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Build up state: x5 pending and three buffered results behind a busy pipeline.
    drive(0, 0, 0, 0, 0, 0, 1, 5);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 3, 32'h100 + i, 1, 5'(20 + i), 32'h200 + i, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    query(5, 0, 0);
    #2;
    checks++; if (q_stall !== 1'b1) begin errors++; $display("FAIL pre_rst_stall: got %b want 1", q_stall); end
    checks++; if (rf_a !== 5'd20) begin errors++; $display("FAIL pre_rst_head: got %0d want 20", rf_a); end
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we: got %b want 0", rf_we); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL rst_lu_ready: got %b want 1", lu_ready); end
    checks++; if (q_stall !== 1'b0) begin errors++; $display("FAIL rst_q_stall: got %b want 0", q_stall); end
    checks++; if (wb_hold !== 1'b0) begin errors++; $display("FAIL rst_wb_hold: got %b want 0", wb_hold); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #3;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL post_rst_rf_we: got %b want 0", rf_we); end
    #1;
  endtask

  task automatic test_priority();
    apply_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    tick();
    drive(1, 3, 32'hAA, 1, 7, 32'h11, 0, 0);
    tick();
    drive(1, 3, 32'hAA, 0, 0, 0, 0, 0);
    query(7, 0, 0);
    #2;
    checks++; if (rf_we !== 1'b1 || rf_a !== 5'd3 || rf_wd !== 32'hAA) begin
      errors++; $display("FAIL prio_pipe: got we=%b a=%0d wd=%h want we=1 a=3 wd=aa", rf_we, rf_a, rf_wd);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checks++; if (rf_we !== 1'b1 || rf_a !== 5'd7 || rf_wd !== 32'h11) begin
      errors++; $display("FAIL prio_fifo: got we=%b a=%0d wd=%h want we=1 a=7 wd=11", rf_we, rf_a, rf_wd);
    end
    checks++; if (q_stall !== 1'b1) begin errors++; $display("FAIL prio_stall_pop: got %b want 1", q_stall); end
    tick();
    #2;
    checks++; if (q_stall !== 1'b0) begin errors++; $display("FAIL prio_stall_clr: got %b want 0", q_stall); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL prio_idle: got %b want 0", rf_we); end
    tick();
  endtask

  task automatic test_scoreboard();
    apply_reset();
    query(0, 9, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 9);
    #2;
    checks++; if (q_stall !== 1'b0) begin errors++; $display("FAIL sb_issue_cycle: got %b want 0", q_stall); end
    tick();
    drive(1, 3, 32'h1, 1, 9, 32'h99, 0, 0);
    #2;
    checks++; if (q_stall !== 1'b1) begin errors++; $display("FAIL sb_pending: got %b want 1", q_stall); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checks++; if (q_stall !== 1'b1 || rf_a !== 5'd9) begin
      errors++; $display("FAIL sb_pop_cycle: got stall=%b a=%0d want stall=1 a=9", q_stall, rf_a);
    end
    tick();
    #2;
    checks++; if (q_stall !== 1'b0) begin errors++; $display("FAIL sb_cleared: got %b want 0", q_stall); end
    // Reissue x9 in the very cycle its previous result pops.
    drive(0, 0, 0, 0, 0, 0, 1, 9);
    tick();
    drive(1, 3, 32'h2, 1, 9, 32'h9A, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 9);
    #2;
    checks++; if (rf_a !== 5'd9 || rf_wd !== 32'h9A) begin
      errors++; $display("FAIL sb_reissue_pop: got a=%0d wd=%h want a=9 wd=9a", rf_a, rf_wd);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checks++; if (q_stall !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b want 1", q_stall); end
    drive(0, 0, 0, 1, 9, 32'h9B, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    #2;
    checks++; if (q_stall !== 1'b0) begin errors++; $display("FAIL sb_final_clr: got %b want 0", q_stall); end
    tick();
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 3, 32'h30 + i, 1, 5'(10 + i), 32'hD0 + i, 0, 0);
      #2;
      checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %b want 1", i, lu_ready); end
      tick();
    end
    drive(1, 3, 32'h34, 1, 14, 32'hEE, 0, 0);
    #2;
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready: got %b want 0", lu_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      #2;
      checks++; if (rf_we !== 1'b1 || rf_a !== 5'(10 + i) || rf_wd !== 32'hD0 + i) begin
        errors++; $display("FAIL full_drain_%0d: got we=%b a=%0d wd=%h want we=1 a=%0d wd=%h",
                           i, rf_we, rf_a, rf_wd, 10 + i, 32'hD0 + i);
      end
      tick();
    end
    #2;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL full_5th_dropped: got %b want 0", rf_we); end
    tick();
  endtask

  task automatic test_x0();
    apply_reset();
    drive(1, 3, 32'h1, 1, 15, 32'h15F, 0, 0);
    tick();
    drive(1, 0, 32'h77, 0, 0, 0, 0, 0);
    #2;
    checks++; if (rf_we !== 1'b1 || rf_a !== 5'd15 || rf_wd !== 32'h15F) begin
      errors++; $display("FAIL x0_wb_ignored: got we=%b a=%0d wd=%h want we=1 a=15 wd=15f", rf_we, rf_a, rf_wd);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #2;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_popped: got %b want 0", rf_we); end
    tick();
    drive(0, 0, 0, 1, 0, 32'hDEAD, 0, 0);
    query(0, 0, 0);
    #2;
    checks++; if (q_stall !== 1'b0) begin errors++; $display("FAIL x0_iss_stall: got %b want 0", q_stall); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL x0_lu_ready: got %b want 1", lu_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_push_dropped: got %b want 0", rf_we); end
    tick();
  endtask

  task automatic test_starve();
    apply_reset();
    drive(0, 0, 0, 1, 16, 32'h1600, 0, 0);
    tick();
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      drive(1, 4, 32'h40 + i, 0, 0, 0, 0, 0);
      #2;
      checks++; if (wb_hold !== 1'b0) begin errors++; $display("FAIL starve_early_%0d: got %b want 0", i, wb_hold); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
`ifdef CPU_WB_STARVE_GUARD_EN
    checks++; if (wb_hold !== 1'b1) begin errors++; $display("FAIL starve_hold: got %b want 1", wb_hold); end
`else
    checks++; if (wb_hold !== 1'b0) begin errors++; $display("FAIL starve_hold_off: got %b want 0", wb_hold); end
`endif
    checks++; if (rf_we !== 1'b1 || rf_a !== 5'd16) begin
      errors++; $display("FAIL starve_pop: got we=%b a=%0d want we=1 a=16", rf_we, rf_a);
    end
    tick();
    #2;
    checks++; if (wb_hold !== 1'b0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL starve_after: got hold=%b we=%b want 0 0", wb_hold, rf_we);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] outstanding[$];
    bit         iv, wv, lv, slot, e_we;
    logic [4:0] ird, wrd, lrd, e_a;
    logic [31:0] e_wd;
    int         k;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      iv  = ($urandom_range(0, 3) == 0);
      ird = 5'($urandom_range(0, 31));
      if (m_pend[ird]) iv = 1'b0;
      wv  = 1'($urandom_range(0, 1));
      wrd = 5'($urandom_range(0, 31));
      if (m_pend[wrd] || (iv && wrd == ird)) wrd = 5'd0;
      if (m_hold) wv = 1'b0;
      lv = 1'b0; lrd = 5'd0; k = -1;
      if (outstanding.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, outstanding.size() - 1);
        lv = 1'b1;
        lrd = outstanding[k];
      end else if ($urandom_range(0, 15) == 0) begin
        lv = 1'b1;
      end
      drive(wv, wrd, $urandom, lv, lrd, $urandom, iv, ird);
      query(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      #2;
      slot = wv && wrd != 0;
      e_we = slot || m_rd.size() > 0;
      e_a  = slot ? wrd : (m_rd.size() > 0 ? m_rd[0] : 5'd0);
      e_wd = slot ? wb_data : (m_rd.size() > 0 ? m_data[0] : 32'd0);
      checks++; if (rf_we !== e_we) begin errors++; $display("FAIL rnd_we[%0d]: got %b want %b", n, rf_we, e_we); end
      if (e_we) begin
        checks++; if (rf_a !== e_a || rf_wd !== e_wd) begin
          errors++; $display("FAIL rnd_port[%0d]: got a=%0d wd=%h want a=%0d wd=%h", n, rf_a, rf_wd, e_a, e_wd);
        end
      end
      checks++; if (lu_ready !== (m_rd.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, lu_ready, m_rd.size() < DEPTH);
      end
      checks++; if (q_stall !== (m_pend[q_rs1] || m_pend[q_rs2] || m_pend[q_rd])) begin
        errors++; $display("FAIL rnd_stall[%0d]: got %b rs1=%0d rs2=%0d rd=%0d", n, q_stall, q_rs1, q_rs2, q_rd);
      end
      checks++; if (wb_hold !== m_hold) begin
        errors++; $display("FAIL rnd_hold[%0d]: got %b want %b", n, wb_hold, m_hold);
      end
      if (k >= 0 && m_rd.size() < DEPTH) outstanding.delete(k);
      if (iv && ird != 0) outstanding.push_back(ird);
      tick();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_priority();
    test_scoreboard();
    test_full();
    test_x0();
    test_starve();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_writeback_arbiter.md
Name: cpu_writeback_arbiter

Overview:
- Sits directly upstream of the CPU register file and owns its single write port (address, data, write enable).
- Merges two result sources:
  - the in-order pipeline writeback, which has priority and no backpressure;
  - a long-latency unit (divider or load-miss path), which uses a valid/ready handshake through a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on operands whose long-latency result has not yet been written.

Parameters:
- DEPTH, 4, long-latency result FIFO entries; power of two, minimum 2.
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may go unserviced before a hold is requested (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  pipeline writeback valid
- wb_rd  in  5  pipeline destination register
- wb_data  in  32  pipeline result
- wb_hold  out  1  registered request that the pipeline send no writeback next cycle
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept a result
- lu_rd  in  5  long-latency destination register
- lu_data  in  32  long-latency result
- iss_valid  in  1  long-latency op issued this cycle
- iss_rd  in  5  destination of the issued op
- q_rs1  in  5  decode source 1
- q_rs2  in  5  decode source 2
- q_rd  in  5  decode destination
- q_stall  out  1  operand or destination pending
- rf_we  out  1  register-file write enable
- rf_a  out  5  register-file write address
- rf_wd  out  32  register-file write data

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; clk is the clock.
- On reset:
  - FIFO is emptied, scoreboard is cleared, starvation counter is 0, wb_hold is 0.
  - Therefore rf_we=0 and lu_ready=1.
  - A reset mid-operation discards all buffered results and pending bits.
- Pipeline slot is used when wb_valid=1 and wb_rd!=0. A write with wb_rd=0 is ignored and leaves the slot free.
- Write port (combinational, zero latency; the register file commits on the next clk edge):
  - If the pipeline slot is used: rf_we=1, rf_a=wb_rd, rf_wd=wb_data.
  - Else if the FIFO is non-empty: rf_we=1, rf_a/rf_wd take the FIFO head, and the head pops at the edge.
  - Else: rf_we=0.
- Push: occurs when lu_valid && lu_ready.
  - lu_ready = (count < DEPTH); there is no pass-through when full, even if a pop happens in the same cycle.
  - Pushing with lu_rd=0 stores nothing and completes the handshake.
- Simultaneous push and pop: count is unchanged; pointers wrap modulo DEPTH.
- Scoreboard (31 bits, x0 is never pending):
  - Set on iss_valid && iss_rd!=0.
  - Cleared when a FIFO pop writes that register.
  - If set and clear target the same register in the same cycle, set wins.
- Stall: q_stall = pending[q_rs1] | pending[q_rs2] | pending[q_rd], where index 0 always reads as 0.
- Protocol rules:
  - Decode never issues to a pending rd; q_stall covers this case.
  - A pipeline write to a pending rd cannot occur.
  - Each issued op produces exactly one lu result.

Optional Feature:
- Macro CPU_WB_STARVE_GUARD_EN.
- Defined:
  - A counter increments each cycle the FIFO is non-empty and not popped, and resets to 0 on a pop or when the FIFO is empty.
  - When the count reaches STARVE_LIMIT, wb_hold is registered to 1 for exactly one cycle and the counter clears.
  - The pipeline guarantees wb_valid=0 in that cycle, so the FIFO head pops.
- Not defined: wb_hold is tied to 0 and the counter is absent.

Decomposition:
- Package cpu_wb_pkg holds:
  - XLEN=32 and REG_ADDR_W=5;
  - the FIFO entry type {rd[4:0], data[31:0]};
  - defaults for DEPTH and STARVE_LIMIT.
- Sub-module cpu_wb_fifo: synchronous FIFO with parameter DEPTH. It provides push/pop/full/empty/count and a combinational head output, with asynchronous reset on rst_n.
- The scoreboard, arbitration and starvation logic stay in the top module.

Test Plan:
- Reset: with lu_valid=0, assert rst_n=0 mid-run with 3 FIFO entries and pending x5 → rf_we=0, lu_ready=1, q_stall=0 for q_rs1=5, wb_hold=0.
- Priority:
  - Stimulus: FIFO holds {x7, 0x11}, with wb_valid=1, wb_rd=3, wb_data=0xAA.
  - Required response: rf_a=3, rf_wd=0xAA, and the FIFO is not popped.
  - Next cycle, wb_valid=0 → rf_a=7, rf_wd=0x11, and pending[7] clears.
- Scoreboard:
  - Issue x9, then set q_rs2=9 → q_stall=1 until the cycle after the x9 result is written.
  - Issue x9 in the same cycle x9 pops (a new op) → pending[9] stays 1.
- Full:
  - With wb_valid held at 1 with rd!=0 and the guard off, push DEPTH=4 results.
  - Then lu_ready=0, and a 5th lu_valid is not accepted.
  - Drop wb_valid → 4 consecutive pops follow, in push order.
- x0 handling: wb_rd=0 with a FIFO entry present → the FIFO pops that cycle. iss_rd=0 → q_stall stays 0. A push with lu_rd=0 → count unchanged.
- Starvation (CPU_WB_STARVE_GUARD_EN, STARVE_LIMIT=8):
  - Stimulus: FIFO non-empty, with wb_valid=1 and rd=4 every cycle.
  - Required response: wb_hold=1 for one cycle after the 8th starved cycle.
  - Bench drops wb_valid in that cycle → the FIFO pops.
